// File: rtl/adder_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adder_arb_pkg
//  Brief    : Shared types and helpers for the adder arbiter: FSM state
//             encoding, adder width and the round-robin pointer advance.
//  Revision : 1.0 - initial release
// ============================================================================
package adder_arb_pkg;

    // Arbiter FSM states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Width of the shared parallel_adder; operand width must match it
    localparam int ADDER_W = 4;

    // Advance the round-robin pointer by one, wrapping n-1 back to 0
    function automatic int unsigned next_rr_ptr(input int unsigned ptr, input int unsigned n);
        if (ptr + 1 >= n) begin
            return 0;
        end
        return ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/parallel_adder.sv
`default_nettype none
// ============================================================================
//  Module   : parallel_adder
//  Brief    : 4-bit combinational adder, sum modulo 16 with separate carry.
//  Revision : 1.0 - initial release
// ============================================================================
module parallel_adder (
    output logic [3:0] sum,
    output logic       carry_out,
    input  logic [3:0] A,
    input  logic [3:0] B
);

    // Zero-extend both operands so the fifth bit of the result is the carry
    assign {carry_out, sum} = {1'b0, A} + {1'b0, B};

endmodule
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker
//  Brief    : Combinational request picker. Default build searches upward
//             from the pointer with wrap-around (round-robin). When the
//             macro ADDER_ARB_FIXED_PRIO_EN is defined the lowest requesting
//             index always wins and the pointer is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

`ifdef ADDER_ARB_FIXED_PRIO_EN
    // The pointer has no meaning under fixed priority
    logic w_unused_ptr;
    assign w_unused_ptr = ^ptr;

    // Lowest requesting index wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && req[k]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(k);
                grant[k]  = 1'b1;
            end
        end
    end
`else
    int w_scan;

    // Scan ptr, ptr+1, ... wrapping at NUM_REQ; first requester found wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        w_scan    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = int'(ptr) + k;
            if (w_scan >= NUM_REQ) begin
                w_scan = w_scan - NUM_REQ;
            end
            if (!grant_any && req[w_scan]) begin
                grant_any     = 1'b1;
                grant_idx     = ID_W'(w_scan);
                grant[w_scan] = 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : adder_arbiter
//  Brief    : Shares one parallel_adder among NUM_REQ requesters. A request
//             is accepted in IDLE, its operands are registered, the adder
//             result is captured in EXEC and returned tagged with the
//             requester id in RESP until the consumer takes it.
//             Build option: define ADDER_ARB_FIXED_PRIO_EN for fixed
//             priority (lowest index wins, no round-robin pointer).
//  Revision : 1.0 - initial release
// ============================================================================
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = ADDER_W,   // must equal ADDER_W
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_sum,
    output logic                      rsp_carry,
    output logic [ID_W-1:0]           rsp_id
);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic [ID_W-1:0]     r_op_id;
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic [ID_W-1:0]     w_rr_ptr;
    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_grant_idx;
    logic                w_grant_any;
    logic [DATA_W-1:0]   w_sel_a;
    logic [DATA_W-1:0]   w_sel_b;
    logic [DATA_W-1:0]   w_sum;
    logic                w_carry;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req       (req_valid),
        .ptr       (w_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_any (w_grant_any)
    );

    parallel_adder u_adder (
        .sum       (w_sum),
        .carry_out (w_carry),
        .A         (r_op_a),
        .B         (r_op_b)
    );

    assign w_sel_a = req_a[w_grant_idx*DATA_W +: DATA_W];
    assign w_sel_b = req_b[w_grant_idx*DATA_W +: DATA_W];

`ifdef ADDER_ARB_FIXED_PRIO_EN
    assign w_rr_ptr = '0;
`else
    logic [ID_W-1:0] r_rr_ptr;

    // Next search starts just above the requester whose result was consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (r_state == RESP && rsp_ready) begin
            r_rr_ptr <= ID_W'(next_rr_ptr(32'(r_op_id), NUM_REQ));
        end
    end

    assign w_rr_ptr = r_rr_ptr;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and accept strobe; ready is held low while reset is asserted
    // so no handshake can complete during reset
    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        case (r_state)
            IDLE: begin
                if (w_grant_any && rst_n) begin
                    req_ready    = w_grant;
                    w_next_state = EXEC;
                end
            end
            EXEC: w_next_state = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Operand capture on accept, result capture in EXEC, release in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_id   <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_any) begin
                        r_op_a  <= w_sel_a;
                        r_op_b  <= w_sel_b;
                        r_op_id <= w_grant_idx;
                    end
                end
                EXEC: begin
                    rsp_sum   <= w_sum;
                    rsp_carry <= w_carry;
                    rsp_id    <= r_op_id;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_arbiter
//  Brief    : Scoreboard bench for adder_arbiter. Accepted requests push the
//             arithmetically expected result; a monitor pops and compares
//             every consumed response.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;

    localparam int N  = 4;
    localparam int DW = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_sum;
    logic            rsp_carry;
    logic [1:0]      rsp_id;

    adder_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id)
    );

    typedef struct {
        int sum;
        int carry;
        int id;
        int gcyc;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   grant_cyc[$];
    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   m_ptr      = 0;
    int   mode       = 0;   // 0: drop after accept, 1: re-request at once, 2: random
    int   idle_cnt   = 0;
    int   last_sum   = -1;
    int   last_carry = -1;
    int   last_id    = -1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Winner from the arbitration rule: first valid at or above the pointer
    function automatic int exp_winner(input logic [N-1:0] v, input int ptr);
`ifdef ADDER_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) begin
            if (v[k]) return k;
        end
`else
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
`endif
        return -1;
    endfunction

    task automatic set_req(input int i, input int a, input int b);
        req_a[i*DW +: DW] = DW'(a);
        req_b[i*DW +: DW] = DW'(b);
        req_valid[i]      = 1'b1;
    endtask

    task automatic new_req(input int i);
        set_req(i, int'($urandom_range(15)), int'($urandom_range(15)));
    endtask

    // One clock: observe grant at negedge, then drive new inputs after posedge
    task automatic step();
        int w;
        int a;
        int b;
        int s;
        int acc;
        acc = -1;
        @(negedge clk);
        if (rst_n) begin
            if (req_ready != '0) begin
                idle_cnt = 0;
                w = exp_winner(req_valid, m_ptr);
                chk("grant", int'(req_ready), (w < 0) ? 0 : (1 << w));
                if (w >= 0) begin
                    a = int'(req_a[w*DW +: DW]);
                    b = int'(req_b[w*DW +: DW]);
                    s = a + b;
                    sb.push_back('{s % 16, s / 16, w, cyc});
                    grant_log.push_back(w);
                    grant_cyc.push_back(cyc);
                    m_ptr = (w + 1) % N;
                    acc   = w;
                end
            end else if (req_valid != '0 && !rsp_valid) begin
                idle_cnt++;
                if (idle_cnt > 4) begin
                    chk("grant_timeout", 0, 1);
                    idle_cnt = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        if (acc >= 0) begin
            if (mode == 1) new_req(acc);
            else if (mode == 2 && $urandom_range(1) == 1) new_req(acc);
            else req_valid[acc] = 1'b0;
        end
        if (mode == 2) begin
            for (int i = 0; i < N; i++) begin
                if (i != acc) begin
                    if (!req_valid[i]) begin
                        if ($urandom_range(99) < 30) new_req(i);
                    end else if ($urandom_range(99) < 5) begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            rsp_ready = ($urandom_range(99) < 70);
        end
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 60; k++) begin
            if (req_valid == '0 && sb.size() == 0 && !rsp_valid) break;
            step();
        end
        if (k == 60) chk("drain_timeout", 1, 0);
    endtask

    // Monitor: legality every cycle, scoreboard compare on each consumed result
    initial begin
        logic pv;
        logic pr;
        int   ps;
        int   pc;
        int   pid;
        int   wcnt;
        exp_t e;
        pv = 1'b0; pr = 1'b0; ps = 0; pc = 0; pid = 0; wcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv   = 1'b0;
                wcnt = 0;
            end else begin
                chk("ready_legal", int'($onehot0(req_ready) && ((req_ready & ~req_valid) == '0)), 1);
                if (rsp_valid) begin
                    wcnt = 0;
                    chk("ready_while_rsp", int'(req_ready), 0);
                    if (!pv) begin
                        if (sb.size() == 0) chk("spurious_rsp", 1, 0);
                        else chk("rsp_latency", cyc, sb[0].gcyc + 2);
                    end else if (!pr) begin
                        chk("hold_sum", int'(rsp_sum), ps);
                        chk("hold_carry", int'(rsp_carry), pc);
                        chk("hold_id", int'(rsp_id), pid);
                    end
                    if (rsp_ready) begin
                        if (sb.size() == 0) begin
                            chk("rsp_unexpected", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            chk("rsp_sum", int'(rsp_sum), e.sum);
                            chk("rsp_carry", int'(rsp_carry), e.carry);
                            chk("rsp_id", int'(rsp_id), e.id);
                            last_sum   = int'(rsp_sum);
                            last_carry = int'(rsp_carry);
                            last_id    = int'(rsp_id);
                        end
                    end
                end else if (sb.size() > 0) begin
                    wcnt++;
                    if (wcnt > 6) begin
                        chk("rsp_timeout", 0, 1);
                        wcnt = 0;
                    end
                end
                pv  = rsp_valid;
                pr  = rsp_ready;
                ps  = int'(rsp_sum);
                pc  = int'(rsp_carry);
                pid = int'(rsp_id);
            end
        end
    end

    initial begin
        int n;
        int rel;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Outputs stay zero under reset regardless of requests
        repeat (3) begin
            @(posedge clk);
            #1;
            req_valid = N'($urandom);
            req_a     = (N*DW)'($urandom);
            req_b     = (N*DW)'($urandom);
            @(negedge clk);
            chk("rst_req_ready", int'(req_ready), 0);
            chk("rst_rsp_valid", int'(rsp_valid), 0);
            chk("rst_rsp_sum", int'(rsp_sum), 0);
            chk("rst_rsp_carry", int'(rsp_carry), 0);
            chk("rst_rsp_id", int'(rsp_id), 0);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b1;

        // Fairness: everyone requesting continuously
        rsp_ready = 1'b1;
        mode      = 1;
        grant_log.delete();
        grant_cyc.delete();
        for (int i = 0; i < N; i++) new_req(i);
        for (int k = 0; k < 40 && grant_log.size() < 6; k++) step();
        chk("fair_count", grant_log.size(), 6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
            chk("fair_order", grant_log[k], 0);
`else
            chk("fair_order", grant_log[k], k % N);
`endif
        end
        for (int k = 1; k < 6 && k < grant_cyc.size(); k++) begin
            chk("fair_interval", grant_cyc[k] - grant_cyc[k-1], 3);
        end
        mode = 0;
        drain();

        // Single request from requester 1
        n = grant_log.size();
        set_req(1, 4'b1010, 4'b0101);
        step();
        chk("single_grant", (grant_log.size() > n) ? grant_log[$] : -1, 1);
        drain();
        chk("single_sum", last_sum, 15);
        chk("single_carry", last_carry, 0);
        chk("single_id", last_id, 1);

        // Overflow and small operands
        set_req(0, 15, 15);
        drain();
        chk("ovf_sum", last_sum, 14);
        chk("ovf_carry", last_carry, 1);
        chk("ovf_id", last_id, 0);
        set_req(0, 1, 1);
        drain();
        chk("small_sum", last_sum, 2);
        chk("small_carry", last_carry, 0);

        // Backpressure: result held for five cycles with a request pending
        rsp_ready = 1'b0;
        new_req(3);
        for (int k = 0; k < 10 && !rsp_valid; k++) step();
        chk("bp_rsp_seen", int'(rsp_valid), 1);
        new_req(0);
        repeat (5) step();
        rsp_ready = 1'b1;
        rel = cyc;
        n   = grant_cyc.size();
        step();
        step();
        chk("bp_next_grant", (grant_cyc.size() > n) ? grant_cyc[$] : -1, rel + 1);
        drain();

        // Reset while the operation is in EXEC
        n = grant_log.size();
        new_req(2);
        for (int k = 0; k < 10 && grant_log.size() == n; k++) step();
        rst_n     = 1'b0;
        sb.delete();
        req_valid = '0;
        m_ptr     = 0;
        @(negedge clk);
        chk("rst_mid_valid", int'(rsp_valid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            step();
            chk("no_rsp_after_reset", int'(rsp_valid), 0);
        end
        n = grant_log.size();
        for (int i = 0; i < N; i++) new_req(i);
        for (int k = 0; k < 10 && grant_log.size() == n; k++) step();
        chk("ptr_after_reset", (grant_log.size() > n) ? grant_log[$] : -1, 0);
        drain();

        // Random traffic with random backpressure
        mode = 2;
        repeat (300) step();
        mode      = 0;
        rsp_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
